aclk_set_ctrl: RTL and testbench



---
 rtl/aclk_set_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_aclk_set_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_set_ctrl.sv
// Button-driven setting controller: edits HH:MM for time or alarm and
// commits it through single-cycle load pulses; drives AL_ON and STOP_al.
// Ports: clk, reset (sync, active-high); i_btn_* one-cycle button pulses;
//   i_alarm and i_h_out1/i_h_out0/i_m_out1/i_m_out0 (current BCD time) from
//   the core; o_h_in1/o_h_in0/o_m_in1/o_m_in0 BCD load value; o_ld_time,
//   o_ld_alarm, o_stop_al pulses; o_al_on level; o_busy; o_edit_field.
// Optional snooze state and button: define ACLK_SNOOZE_EN.
module aclk_set_ctrl #(
  parameter int TIMEOUT_CYC = 300,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_set_time,
  input  logic       i_btn_set_alarm,
  input  logic       i_btn_inc,
  input  logic       i_btn_next,
  input  logic       i_btn_cancel,
  input  logic       i_btn_al_toggle,
  input  logic       i_btn_stop,
  input  logic       i_btn_snooze,
  input  logic       i_alarm,
  input  logic [1:0] i_h_out1,
  input  logic [3:0] i_h_out0,
  input  logic [3:0] i_m_out1,
  input  logic [3:0] i_m_out0,
  output logic [1:0] o_h_in1,
  output logic [3:0] o_h_in0,
  output logic [3:0] o_m_in1,
  output logic [3:0] o_m_in0,
  output logic       o_ld_time,
  output logic       o_ld_alarm,
  output logic       o_stop_al,
  output logic       o_al_on,
  output logic       o_busy,
  output logic [1:0] o_edit_field
);

  localparam int LP_CW = $clog2(TIMEOUT_CYC);
  localparam logic [LP_CW-1:0] LP_TMAX = LP_CW'(TIMEOUT_CYC - 1);

`ifdef ACLK_SNOOZE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_H, S_EDIT_M, S_COMMIT, S_SNOOZE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_H, S_EDIT_M, S_COMMIT
  } state_t;
`endif

  state_t r_state, w_state;

  logic             r_tgt_alarm, w_tgt_alarm;
  logic [1:0]       r_eh1, w_eh1, r_ah1, w_ah1, r_hi1, w_hi1;
  logic [3:0]       r_eh0, w_eh0, r_ah0, w_ah0, r_hi0, w_hi0;
  logic [3:0]       r_em1, w_em1, r_am1, w_am1, r_mi1, w_mi1;
  logic [3:0]       r_em0, w_em0, r_am0, w_am0, r_mi0, w_mi0;
  logic [LP_CW-1:0] r_cnt, w_cnt;
  logic             r_ld_time, w_ld_time;
  logic             r_ld_alarm, w_ld_alarm;
  logic             r_stop_al, w_stop_al;
  logic             r_al_on, w_al_on;
  logic             r_busy, w_busy;
  logic [1:0]       r_field, w_field;
  logic             w_acc;

  logic [1:0] w_hinc1;
  logic [3:0] w_hinc0, w_minc1, w_minc0;

  // BCD increment of the edit fields; no carry from minutes into hours.
  always_comb begin
    w_hinc1 = r_eh1;
    w_hinc0 = r_eh0 + 4'd1;
    if (r_eh1 == 2'd2 && r_eh0 == 4'd3) begin
      w_hinc1 = 2'd0;
      w_hinc0 = 4'd0;
    end else if (r_eh0 == 4'd9) begin
      w_hinc1 = r_eh1 + 2'd1;
      w_hinc0 = 4'd0;
    end
    w_minc1 = r_em1;
    w_minc0 = r_em0 + 4'd1;
    if (r_em1 == 4'd5 && r_em0 == 4'd9) begin
      w_minc1 = 4'd0;
      w_minc0 = 4'd0;
    end else if (r_em0 == 4'd9) begin
      w_minc1 = r_em1 + 4'd1;
      w_minc0 = 4'd0;
    end
  end

`ifdef ACLK_SNOOZE_EN
  logic [6:0] w_sm;
  logic [4:0] w_sh;
  logic [1:0] w_snz_h1;
  logic [3:0] w_snz_h0, w_snz_m1, w_snz_m0;

  // Current time plus SNOOZE_MIN minutes, rebuilt as BCD.
  always_comb begin
    w_sm = 7'(i_m_out1) * 7'd10 + 7'(i_m_out0) + 7'(SNOOZE_MIN);
    w_sh = 5'(i_h_out1) * 5'd10 + 5'(i_h_out0);
    if (w_sm >= 7'd60) begin
      w_sm = w_sm - 7'd60;
      w_sh = (w_sh >= 5'd23) ? 5'd0 : w_sh + 5'd1;
    end
    w_snz_m1 = 4'(w_sm / 7'd10);
    w_snz_m0 = 4'(w_sm % 7'd10);
    w_snz_h1 = 2'(w_sh / 5'd10);
    w_snz_h0 = 4'(w_sh % 5'd10);
  end
`else
  logic w_unused;
  assign w_unused = i_btn_snooze | i_alarm | (SNOOZE_MIN == 0);
`endif

  always_comb begin
    w_state     = r_state;
    w_tgt_alarm = r_tgt_alarm;
    w_eh1 = r_eh1; w_eh0 = r_eh0;
    w_em1 = r_em1; w_em0 = r_em0;
    w_ah1 = r_ah1; w_ah0 = r_ah0;
    w_am1 = r_am1; w_am0 = r_am0;
    w_hi1 = r_hi1; w_hi0 = r_hi0;
    w_mi1 = r_mi1; w_mi0 = r_mi0;
    w_cnt      = '0;
    w_ld_time  = 1'b0;
    w_ld_alarm = 1'b0;
    w_stop_al  = i_btn_stop;
    w_al_on    = r_al_on ^ i_btn_al_toggle;
    w_acc = i_btn_cancel | i_btn_next | i_btn_inc
          | i_btn_al_toggle | i_btn_stop;
    unique case (r_state)
      S_IDLE: begin
`ifdef ACLK_SNOOZE_EN
        if (i_btn_snooze && i_alarm) begin
          w_state    = S_SNOOZE;
          w_stop_al  = 1'b1;
          w_ld_alarm = 1'b1;
          w_hi1 = w_snz_h1; w_hi0 = w_snz_h0;
          w_mi1 = w_snz_m1; w_mi0 = w_snz_m0;
          w_ah1 = w_snz_h1; w_ah0 = w_snz_h0;
          w_am1 = w_snz_m1; w_am0 = w_snz_m0;
        end else
`endif
        if (i_btn_set_time) begin
          w_state     = S_EDIT_H;
          w_tgt_alarm = 1'b0;
          w_eh1 = i_h_out1; w_eh0 = i_h_out0;
          w_em1 = i_m_out1; w_em0 = i_m_out0;
        end else if (i_btn_set_alarm) begin
          w_state     = S_EDIT_H;
          w_tgt_alarm = 1'b1;
          w_eh1 = r_ah1; w_eh0 = r_ah0;
          w_em1 = r_am1; w_em0 = r_am0;
        end
      end
      S_EDIT_H, S_EDIT_M: begin
        if (w_acc) begin
          w_cnt = '0;
        end else if (r_cnt == LP_TMAX) begin
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + LP_CW'(1);
        end
        if (i_btn_cancel) begin
          w_state = S_IDLE;
        end else if (i_btn_next) begin
          if (r_state == S_EDIT_H) begin
            w_state = S_EDIT_M;
          end else begin
            w_state = S_COMMIT;
            w_hi1 = r_eh1; w_hi0 = r_eh0;
            w_mi1 = r_em1; w_mi0 = r_em0;
            w_ld_time  = ~r_tgt_alarm;
            w_ld_alarm = r_tgt_alarm;
            if (r_tgt_alarm) begin
              w_ah1 = r_eh1; w_ah0 = r_eh0;
              w_am1 = r_em1; w_am0 = r_em0;
            end
          end
        end else if (i_btn_inc) begin
          if (r_state == S_EDIT_H) begin
            w_eh1 = w_hinc1; w_eh0 = w_hinc0;
          end else begin
            w_em1 = w_minc1; w_em0 = w_minc0;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy  = (w_state != S_IDLE);
    w_field = (w_state == S_EDIT_H) ? 2'b01 :
              (w_state == S_EDIT_M) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tgt_alarm <= 1'b0;
      r_eh1 <= '0; r_eh0 <= '0; r_em1 <= '0; r_em0 <= '0;
      r_ah1 <= '0; r_ah0 <= '0; r_am1 <= '0; r_am0 <= '0;
      r_hi1 <= '0; r_hi0 <= '0; r_mi1 <= '0; r_mi0 <= '0;
      r_cnt      <= '0;
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_stop_al  <= 1'b0;
      r_al_on    <= 1'b0;
      r_busy     <= 1'b0;
      r_field    <= 2'b00;
    end else begin
      r_state     <= w_state;
      r_tgt_alarm <= w_tgt_alarm;
      r_eh1 <= w_eh1; r_eh0 <= w_eh0; r_em1 <= w_em1; r_em0 <= w_em0;
      r_ah1 <= w_ah1; r_ah0 <= w_ah0; r_am1 <= w_am1; r_am0 <= w_am0;
      r_hi1 <= w_hi1; r_hi0 <= w_hi0; r_mi1 <= w_mi1; r_mi0 <= w_mi0;
      r_cnt      <= w_cnt;
      r_ld_time  <= w_ld_time;
      r_ld_alarm <= w_ld_alarm;
      r_stop_al  <= w_stop_al;
      r_al_on    <= w_al_on;
      r_busy     <= w_busy;
      r_field    <= w_field;
    end
  end

  assign o_h_in1      = r_hi1;
  assign o_h_in0      = r_hi0;
  assign o_m_in1      = r_mi1;
  assign o_m_in0      = r_mi0;
  assign o_ld_time    = r_ld_time;
  assign o_ld_alarm   = r_ld_alarm;
  assign o_stop_al    = r_stop_al;
  assign o_al_on      = r_al_on;
  assign o_busy       = r_busy;
  assign o_edit_field = r_field;

endmodule

// File: tb/tb_aclk_set_ctrl.sv
// Self-checking bench for aclk_set_ctrl: vector table, corner
// sequences and random stimulus against a minutes-based reference model.
module tb_aclk_set_ctrl;

  localparam int T   = 16;
  localparam int SNZ = 5;

  localparam int B_ST  = 1;
  localparam int B_SA  = 2;
  localparam int B_INC = 4;
  localparam int B_NXT = 8;
  localparam int B_CAN = 16;
  localparam int B_TOG = 32;
  localparam int B_STP = 64;
  localparam int B_SNZ = 128;

  logic clk = 1'b0;
  logic reset;
  logic bst, bsa, binc, bnxt, bcan, btog, bstp, bsnz, alarm;
  logic [1:0] h1;
  logic [3:0] h0, m1, m0;
  logic [1:0] hi1;
  logic [3:0] hi0, mi1, mi0;
  logic ldt, lda, stp, alon, busy;
  logic [1:0] fld;

  int total = 0;
  int bad = 0;

  aclk_set_ctrl #(.TIMEOUT_CYC(T), .SNOOZE_MIN(SNZ)) dut (
    .clk(clk), .reset(reset),
    .i_btn_set_time(bst), .i_btn_set_alarm(bsa),
    .i_btn_inc(binc), .i_btn_next(bnxt), .i_btn_cancel(bcan),
    .i_btn_al_toggle(btog), .i_btn_stop(bstp), .i_btn_snooze(bsnz),
    .i_alarm(alarm),
    .i_h_out1(h1), .i_h_out0(h0), .i_m_out1(m1), .i_m_out0(m0),
    .o_h_in1(hi1), .o_h_in0(hi0), .o_m_in1(mi1), .o_m_in0(mi0),
    .o_ld_time(ldt), .o_ld_alarm(lda), .o_stop_al(stp),
    .o_al_on(alon), .o_busy(busy), .o_edit_field(fld)
  );

  always #5 clk = ~clk;

  // Reference model: whole-number hours/minutes, mode 0 idle,
  // 1 hours, 2 minutes, 3 commit, 4 snooze.
  int md_mode, md_tgt_al, md_eh, md_em, md_sh, md_sm, md_idle;
  int md_h, md_m, md_ldt, md_lda, md_stp, md_alon;

  task automatic model_tick();
    int ch, cm, nm, t;
    bit edit_btn;
    if (reset) begin
      md_mode = 0; md_tgt_al = 0; md_eh = 0; md_em = 0;
      md_sh = 0; md_sm = 0; md_idle = 0;
      md_h = 0; md_m = 0; md_ldt = 0; md_lda = 0;
      md_stp = 0; md_alon = 0;
      return;
    end
    ch = int'(h1) * 10 + int'(h0);
    cm = int'(m1) * 10 + int'(m0);
    md_ldt = 0; md_lda = 0;
    md_stp = int'(bstp);
    if (btog) md_alon = 1 - md_alon;
    nm = md_mode;
    edit_btn = bcan | bnxt | binc | btog | bstp;
    if (md_mode == 0) begin
      md_idle = 0;
`ifdef ACLK_SNOOZE_EN
      if (bsnz && alarm) begin
        t = (ch * 60 + cm + SNZ) % 1440;
        md_h = t / 60; md_m = t % 60;
        md_sh = md_h; md_sm = md_m;
        md_lda = 1; md_stp = 1; nm = 4;
      end else
`endif
      if (bst) begin
        md_eh = ch; md_em = cm; md_tgt_al = 0; nm = 1;
      end else if (bsa) begin
        md_eh = md_sh; md_em = md_sm; md_tgt_al = 1; nm = 1;
      end
    end else if (md_mode == 1 || md_mode == 2) begin
      if (bcan) nm = 0;
      else if (bnxt) begin
        if (md_mode == 1) nm = 2;
        else begin
          nm = 3;
          md_h = md_eh; md_m = md_em;
          if (md_tgt_al != 0) begin
            md_lda = 1; md_sh = md_eh; md_sm = md_em;
          end else md_ldt = 1;
        end
      end else if (binc) begin
        if (md_mode == 1) md_eh = (md_eh + 1) % 24;
        else md_em = (md_em + 1) % 60;
      end
      // cycles spent with no button since entering / last press
      if (edit_btn) md_idle = 0;
      else begin
        md_idle++;
        if (md_idle >= T) nm = 0;
      end
    end else nm = 0;
    if (nm != md_mode && (nm == 1 || nm == 2)) md_idle = 0;
    md_mode = nm;
  endtask

  function automatic int mdl_pack();
    int f;
    f = (md_mode == 1) ? 1 : (md_mode == 2) ? 2 : 0;
    return (md_h << 16) | (md_m << 8) | (md_ldt << 6) | (md_lda << 5)
         | (md_stp << 4) | (md_alon << 3) | ((md_mode != 0 ? 1 : 0) << 2) | f;
  endfunction

  function automatic int dut_h();
    return int'(hi1) * 10 + int'(hi0);
  endfunction

  function automatic int dut_m();
    return int'(mi1) * 10 + int'(mi0);
  endfunction

  function automatic int dut_pack();
    return (dut_h() << 16) | (dut_m() << 8) | (int'(ldt) << 6)
         | (int'(lda) << 5) | (int'(stp) << 4) | (int'(alon) << 3)
         | (int'(busy) << 2) | int'(fld);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(int b, int ch, int cm, bit al);
    bst  = b[0]; bsa  = b[1]; binc = b[2]; bnxt = b[3];
    bcan = b[4]; btog = b[5]; bstp = b[6]; bsnz = b[7];
    h1 = 2'(ch / 10); h0 = 4'(ch % 10);
    m1 = 4'(cm / 10); m0 = 4'(cm % 10);
    alarm = al;
  endtask

  task automatic step(string nm);
    @(posedge clk);
    model_tick();
    #1;
    chk(nm, dut_pack(), mdl_pack());
  endtask

  typedef struct {
    int btn, ch, cm;
    int busy, fld, ldt, lda, stp, alon, h, m;
  } vec_t;

  vec_t tv[$];

  initial begin
    // btn cur_h cur_m | busy fld ldt lda stp alon h m
    tv.push_back(vec_t'{B_SA, 0, 0,    1, 1, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 7; i++)
      tv.push_back(vec_t'{B_INC, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_NXT, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++)
      tv.push_back(vec_t'{B_INC, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_NXT, 0, 0,   1, 0, 0, 1, 0, 0, 7, 3});
    tv.push_back(vec_t'{0, 0, 0,       0, 0, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_ST, 23, 59,  1, 1, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_INC, 23, 59, 1, 1, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_NXT, 23, 59, 1, 2, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_INC, 23, 59, 1, 2, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_NXT, 23, 59, 1, 0, 1, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{0, 12, 34,     0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_ST, 12, 34,  1, 1, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_NXT, 12, 34, 1, 2, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_CAN|B_NXT|B_INC, 12, 34,
                                       0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_ST|B_SA, 12, 34,
                                       1, 1, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_NXT, 12, 34, 1, 2, 0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{B_NXT, 12, 34, 1, 0, 1, 0, 0, 0, 12, 34});
    tv.push_back(vec_t'{0, 12, 34,     0, 0, 0, 0, 0, 0, 12, 34});
    tv.push_back(vec_t'{B_SA, 12, 34,  1, 1, 0, 0, 0, 0, 12, 34});
    tv.push_back(vec_t'{B_NXT, 12, 34, 1, 2, 0, 0, 0, 0, 12, 34});
    tv.push_back(vec_t'{B_NXT, 12, 34, 1, 0, 0, 1, 0, 0, 7, 3});
    tv.push_back(vec_t'{0, 12, 34,     0, 0, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_TOG, 1, 2,   0, 0, 0, 0, 0, 1, 7, 3});
    tv.push_back(vec_t'{0, 1, 2,       0, 0, 0, 0, 0, 1, 7, 3});
    tv.push_back(vec_t'{B_TOG, 1, 2,   0, 0, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_ST, 1, 2,    1, 1, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_STP, 1, 2,   1, 1, 0, 0, 1, 0, 7, 3});
    tv.push_back(vec_t'{0, 1, 2,       1, 1, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_INC, 1, 2,   1, 1, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_NXT, 1, 2,   1, 2, 0, 0, 0, 0, 7, 3});
    tv.push_back(vec_t'{B_NXT, 1, 2,   1, 0, 1, 0, 0, 0, 2, 2});
    tv.push_back(vec_t'{0, 1, 2,       0, 0, 0, 0, 0, 0, 2, 2});

    drive(0, 0, 0, 1'b0);
    reset = 1'b1;
    step("reset0");
    step("reset1");
    reset = 1'b0;
    chk("rst_out", dut_pack(), 0);

    foreach (tv[i]) begin
      drive(tv[i].btn, tv[i].ch, tv[i].cm, 1'b0);
      step($sformatf("tv%0d_model", i));
      chk($sformatf("tv%0d_busy", i), int'(busy), tv[i].busy);
      chk($sformatf("tv%0d_fld", i), int'(fld), tv[i].fld);
      chk($sformatf("tv%0d_ld", i), {ldt, lda},
          (tv[i].ldt << 1) | tv[i].lda);
      chk($sformatf("tv%0d_stop", i), int'(stp), tv[i].stp);
      chk($sformatf("tv%0d_alon", i), int'(alon), tv[i].alon);
      chk($sformatf("tv%0d_hm", i), dut_h() * 100 + dut_m(),
          tv[i].h * 100 + tv[i].m);
    end

    // Timeout: T busy cycles from entry, then idle without a load.
    drive(B_ST, 9, 41, 1'b0);
    step("to_enter");
    drive(0, 9, 41, 1'b0);
    for (int i = 1; i < T; i++) begin
      step("to_wait");
      chk("to_busy", int'(busy), 1);
    end
    step("to_exit");
    chk("to_idle", {busy, fld, ldt, lda}, 0);

    // Reset while editing minutes aborts without a load.
    drive(B_ST, 9, 41, 1'b0);
    step("rm_enter");
    drive(B_NXT, 9, 41, 1'b0);
    step("rm_min");
    chk("rm_fld", int'(fld), 2);
    drive(0, 9, 41, 1'b0);
    reset = 1'b1;
    step("rm_reset");
    reset = 1'b0;
    chk("rm_idle", {busy, fld, ldt, lda, stp}, 0);
    step("rm_after");
    chk("rm_ld", {ldt, lda}, 0);

`ifdef ACLK_SNOOZE_EN
    drive(B_SNZ | B_STP, 23, 57, 1'b1);
    step("snz");
    chk("snz_pulse", {stp, lda, ldt}, 3'b110);
    chk("snz_hm", dut_h() * 100 + dut_m(), 2);
    drive(0, 23, 57, 1'b1);
    step("snz_end");
    chk("snz_once", {stp, lda, busy}, 0);
    drive(B_SNZ, 23, 57, 1'b0);
    step("snz_off");
    chk("snz_off", {stp, lda, busy}, 0);
`endif

    // Random traffic; buttons only on even cycles so every press is a
    // single-cycle pulse.
    for (int n = 0; n < 4000; n++) begin
      int b;
      b = 0;
      if (n % 2 == 0) begin
        for (int k = 0; k < 8; k++)
          if ($urandom_range(0, 4) == 0) b |= (1 << k);
      end
      drive(b, int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
            1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 299) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
